seq_pattern_tx: RTL and testbench

//   Bit-serial pattern transmitter; companion to the serial sequence detector.
//   On a start pulse, shifts a programmable LEN-bit pattern out MSB-first, one bit per clk.

---
 rtl/seq_pattern_tx_if.sv | 25 ++
 rtl/seq_pattern_tx.sv | 110 +++++++++++
 tb/tb_seq_pattern_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Control/data bundle for the serial pattern transmitter.
// The master side drives the requests and the slave side drives the serial stream.
interface seq_pattern_tx_if #(
  parameter int LEN = 9
);
  logic           start;
  logic [3:0]     repeat_cnt;
  logic           pat_ld;
  logic [LEN-1:0] pat_in;
  logic           abort;
  logic           out;
  logic           out_valid;
  logic           busy;
  logic           done;

  modport master (
    output start, repeat_cnt, pat_ld, pat_in, abort,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, repeat_cnt, pat_ld, pat_in, abort,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: shifts a LEN-bit pattern out MSB-first,
// repeat_cnt+1 times, with GAP_BITS idle bits between frames.
module seq_pattern_tx #(
  parameter int             LEN      = 9,
  parameter logic [LEN-1:0] PATTERN  = 9'b011010101,
  parameter int             GAP_BITS = 1,
  parameter logic           IDLE_BIT = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seq_pattern_tx_if.slave bus
);
  localparam int IW = $clog2(LEN);
  localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t         r_state;
  logic [LEN-1:0] r_pat;
  logic [IW-1:0]  r_bit_idx;
  logic [3:0]     r_rep_left;
  logic [GW-1:0]  r_gap_cnt;
  logic           r_out;
  logic           r_out_valid;
  logic           r_busy;
  logic           r_done;

  // A same-cycle pat_ld must feed the first transmitted bit.
  logic [LEN-1:0] w_pat_next;
  assign w_pat_next = bus.pat_ld ? bus.pat_in : r_pat;

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pat       <= PATTERN;
      r_bit_idx   <= '0;
      r_rep_left  <= '0;
      r_gap_cnt   <= '0;
      r_out       <= IDLE_BIT;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (r_state != S_IDLE && bus.abort) begin
      r_state     <= S_IDLE;
      r_out       <= IDLE_BIT;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pat <= w_pat_next;
          if (bus.start) begin
            r_state     <= S_SEND;
            r_rep_left  <= bus.repeat_cnt;
            r_bit_idx   <= IW'(LEN - 1);
            r_out       <= w_pat_next[LEN-1];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        // r_bit_idx names the bit currently on the output register
        S_SEND: begin
          if (r_bit_idx == '0) begin
            if (r_rep_left == 4'd0) begin
              r_state     <= S_DONE;
              r_out       <= IDLE_BIT;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else if (GAP_BITS == 0) begin
              r_rep_left  <= r_rep_left - 4'd1;
              r_bit_idx   <= IW'(LEN - 1);
              r_out       <= r_pat[LEN-1];
            end else begin
              r_state     <= S_GAP;
              r_gap_cnt   <= GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
              r_out       <= IDLE_BIT;
              r_out_valid <= 1'b0;
            end
          end else begin
            r_bit_idx <= r_bit_idx - 1'b1;
            r_out     <= r_pat[r_bit_idx - 1'b1];
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state     <= S_SEND;
            r_rep_left  <= r_rep_left - 4'd1;
            r_bit_idx   <= IW'(LEN - 1);
            r_out       <= r_pat[LEN-1];
            r_out_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a frame-list model of the expected serial stream
// compared every cycle, plus directed literal checks of the documented scenarios.
module tb_seq_pattern_tx;
  localparam int             LEN      = 9;
  localparam logic [LEN-1:0] PATTERN  = 9'b011010101;
  localparam int             GAP_BITS = 1;
  localparam logic           IDLE_BIT = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.LEN(LEN)) bus ();

  seq_pattern_tx #(.LEN(LEN), .PATTERN(PATTERN), .GAP_BITS(GAP_BITS), .IDLE_BIT(IDLE_BIT))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: on an accepted start the whole run is expanded into a list of
  // per-cycle expected outputs {out, out_valid, busy, done}.
  typedef struct packed {logic o; logic v; logic b; logic d;} exp_t;
  localparam exp_t IDLE_E = '{IDLE_BIT, 1'b0, 1'b0, 1'b0};
  exp_t           cur;
  exp_t           q[$];
  logic [LEN-1:0] m_pat;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur = IDLE_E;
      q.delete();
      m_pat = PATTERN;
    end else if (!cur.b) begin
      if (bus.pat_ld) m_pat = bus.pat_in;
      if (bus.start) begin
        for (int f = 0; f <= int'(bus.repeat_cnt); f++) begin
          for (int b = LEN - 1; b >= 0; b--) q.push_back('{m_pat[b], 1'b1, 1'b1, 1'b0});
          if (f < int'(bus.repeat_cnt))
            for (int g = 0; g < GAP_BITS; g++) q.push_back('{IDLE_BIT, 1'b0, 1'b1, 1'b0});
        end
        q.push_back('{IDLE_BIT, 1'b0, 1'b1, 1'b1});
        cur = q.pop_front();
      end else begin
        cur = IDLE_E;
      end
    end else if (bus.abort) begin
      q.delete();
      cur = IDLE_E;
    end else begin
      cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("model out",       32'(bus.out),       32'(cur.o));
      chk("model out_valid", 32'(bus.out_valid), 32'(cur.v));
      chk("model busy",      32'(bus.busy),      32'(cur.b));
      chk("model done",      32'(bus.done),      32'(cur.d));
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulse start for one cycle, then check the frame bits literally.
  task automatic start_and_check(input logic [LEN-1:0] p, input logic [3:0] rc, input string nm);
    bus.start = 1'b1;
    bus.repeat_cnt = rc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int b = LEN - 1; b >= 0; b--) begin
      chk({nm, " bit"}, 32'(bus.out), 32'(p[b]));
      chk({nm, " valid"}, 32'(bus.out_valid), 32'd1);
      if (b > 0) @(negedge clk);
    end
  endtask

  logic [LEN-1:0] exp1, exp4;

  initial begin
    bus.start = 1'b0; bus.repeat_cnt = 4'd0; bus.pat_ld = 1'b0;
    bus.pat_in = '0; bus.abort = 1'b0;
    exp1 = 9'b011010101;
    exp4 = 9'b101100111;
    #12;
    chk("reset out",       32'(bus.out),       32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset busy",      32'(bus.busy),      32'd0);
    chk("reset done",      32'(bus.done),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // Default pattern, single frame
    start_and_check(exp1, 4'd0, "t1");
    @(negedge clk);
    chk("t1 done", 32'(bus.done), 32'd1);
    chk("t1 busy in done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("t1 busy after", 32'(bus.busy), 32'd0);
    chk("t1 done after", 32'(bus.done), 32'd0);
    idle_cycles(2);

    // Three frames with one gap bit between them; done on cycle 30
    bus.start = 1'b1; bus.repeat_cnt = 4'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.repeat_cnt = 4'd7;
    for (int c = 1; c < 30; c++) begin
      if (c == 10 || c == 20) begin
        chk("t2 gap out", 32'(bus.out), 32'd1);
        chk("t2 gap valid", 32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
    end
    chk("t2 done at 30", 32'(bus.done), 32'd1);
    idle_cycles(3);

    // Load a pattern, start next cycle, ignore a load while sending
    bus.pat_ld = 1'b1; bus.pat_in = exp4;
    @(negedge clk);
    bus.pat_ld = 1'b0;
    bus.pat_in = '0;
    start_and_check(exp4, 4'd0, "t4a");
    bus.pat_ld = 1'b1;
    bus.pat_in = 9'b000011110;
    idle_cycles(1);
    bus.pat_ld = 1'b0;
    idle_cycles(3);
    start_and_check(exp4, 4'd0, "t4b");
    idle_cycles(3);

    // Same-cycle load and start
    bus.pat_ld = 1'b1; bus.pat_in = 9'b110010011;
    start_and_check(9'b110010011, 4'd0, "t4c");
    bus.pat_ld = 1'b0;
    idle_cycles(3);

    // Start while busy ignored; abort on the 4th bit
    bus.start = 1'b1; bus.repeat_cnt = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5 busy after abort", 32'(bus.busy), 32'd0);
    chk("t5 valid after abort", 32'(bus.out_valid), 32'd0);
    chk("t5 out after abort", 32'(bus.out), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5 no done", 32'(bus.done), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.start      = ($urandom_range(0, 5) == 0);
      bus.repeat_cnt = 4'($urandom_range(0, 3));
      bus.pat_ld     = ($urandom_range(0, 7) == 0);
      bus.pat_in     = LEN'($urandom);
      bus.abort      = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.pat_ld = 1'b0; bus.abort = 1'b0;
    idle_cycles(60);

    // Async reset mid-frame drops a loaded pattern
    bus.pat_ld = 1'b1; bus.pat_in = exp4;
    @(negedge clk);
    bus.pat_ld = 1'b0;
    bus.start = 1'b1; bus.repeat_cnt = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    idle_cycles(3);
    #2 rst = 1'b0;
    #1;
    chk("t6 async out", 32'(bus.out), 32'd1);
    chk("t6 async busy", 32'(bus.busy), 32'd0);
    chk("t6 async valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(1);
    start_and_check(exp1, 4'd0, "t6 default");
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
